// File: rtl/pic_host_sequencer_if.sv
// CPU-port bus between the host sequencer and the 8259 PIC.
// The master drives the strobes and write data, and the slave returns INT and the vector byte.
interface pic_host_sequencer_if;
    logic       CS_n;
    logic       WR_n;
    logic       INTA_n;
    logic       A0;
    logic [7:0] DATA_OUT;
    logic [7:0] DATA_IN;
    logic       INT;

    modport master (
        output CS_n, WR_n, INTA_n, A0, DATA_OUT,
        input  DATA_IN, INT
    );

    modport slave (
        input  CS_n, WR_n, INTA_n, A0, DATA_OUT,
        output DATA_IN, INT
    );
endinterface

// File: rtl/pic_host_sequencer.sv
// Host-side 8259 bus master: ICW init sequence, OCW writes and the two-pulse INTA
// acknowledge with vector capture and an optional non-specific EOI.
module pic_host_sequencer #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_init,
    input  logic [7:0]                  icw1,
    input  logic [7:0]                  icw2,
    input  logic [7:0]                  icw3,
    input  logic [7:0]                  icw4,
    input  logic                        eoi_en,
    input  logic                        cmd_valid,
    input  logic                        cmd_a0,
    input  logic [7:0]                  cmd_data,
    output logic                        cmd_ready,
    pic_host_sequencer_if.master        bus,
    output logic [7:0]                  vector,
    output logic                        vector_valid,
    output logic                        init_done,
    output logic                        busy
);
    localparam int unsigned MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DONE_LD  = CW'(GAP_CYCLES);

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        WR_GAP,
        ACK1,
        ACK_GAP,
        ACK2,
        ACK_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            int_meta_q, int_meta_d;
    logic            int_sync_q, int_sync_d;
    logic [3:0][7:0] icw_q, icw_d;
    logic [1:0]      step_q, step_d;
    logic            in_init_q, in_init_d;
    logic            init_done_q, init_done_d;
    logic            a0_q, a0_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      vector_q, vector_d;
    logic            vvalid_q, vvalid_d;

    logic [1:0]      nxt_step;
    logic            nxt_ok;

    // Next ICW index: ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1.
    always_comb begin
        nxt_ok   = 1'b0;
        nxt_step = step_q;
        case (step_q)
            2'd0: begin
                nxt_ok   = 1'b1;
                nxt_step = 2'd1;
            end
            2'd1: begin
                if (!icw_q[0][1]) begin
                    nxt_ok   = 1'b1;
                    nxt_step = 2'd2;
                end else if (icw_q[0][0]) begin
                    nxt_ok   = 1'b1;
                    nxt_step = 2'd3;
                end
            end
            2'd2: begin
                if (icw_q[0][0]) begin
                    nxt_ok   = 1'b1;
                    nxt_step = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        int_meta_d  = bus.INT;
        int_sync_d  = int_meta_q;
        icw_d       = icw_q;
        step_d      = step_q;
        in_init_d   = in_init_q;
        init_done_d = init_done_q;
        a0_d        = a0_q;
        dout_d      = dout_q;
        vector_d    = vector_q;
        vvalid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_init) begin
                    init_done_d = 1'b0;
                    icw_d       = {icw4, icw3, icw2, icw1};
                    in_init_d   = 1'b1;
                    step_d      = 2'd0;
                    a0_d        = 1'b0;
                    dout_d      = icw1;
                    state_d     = WR_SETUP;
                    cnt_d       = '0;
                end else if (init_done_q && int_sync_q) begin
                    state_d = ACK1;
                    cnt_d   = PULSE_LD;
                end else if (init_done_q && cmd_valid) begin
                    a0_d    = cmd_a0;
                    dout_d  = cmd_data;
                    state_d = WR_SETUP;
                    cnt_d   = '0;
                end
            end
            WR_SETUP: begin
                state_d = WR_STROBE;
                cnt_d   = PULSE_LD;
            end
            WR_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                    cnt_d   = '0;
                end
            end
            WR_HOLD: begin
                state_d = WR_GAP;
                cnt_d   = GAP_LD;
            end
            WR_GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (in_init_q) begin
                        if (nxt_ok) begin
                            step_d  = nxt_step;
                            a0_d    = 1'b1;
                            dout_d  = icw_q[nxt_step];
                            state_d = WR_SETUP;
                            cnt_d   = '0;
                        end else begin
                            in_init_d   = 1'b0;
                            init_done_d = 1'b1;
                        end
                    end
                end
            end
            ACK1: begin
                if (cnt_q == '0) begin
                    state_d = ACK_GAP;
                    cnt_d   = GAP_LD;
                end
            end
            ACK_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ACK2;
                    cnt_d   = PULSE_LD;
                end
            end
            ACK2: begin
                if (cnt_q == '0) begin
                    vector_d = bus.DATA_IN;
                    vvalid_d = 1'b1;
                    state_d  = ACK_DONE;
                    cnt_d    = DONE_LD;
                end
            end
            ACK_DONE: begin
                // One vector_valid cycle plus GAP_CYCLES idle, all inside this state.
                if (cnt_q == '0) begin
                    if (eoi_en) begin
                        a0_d    = 1'b0;
                        dout_d  = 8'h20;
                        state_d = WR_SETUP;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            int_meta_q  <= 1'b0;
            int_sync_q  <= 1'b0;
            icw_q       <= '0;
            step_q      <= '0;
            in_init_q   <= 1'b0;
            init_done_q <= 1'b0;
            a0_q        <= 1'b0;
            dout_q      <= '0;
            vector_q    <= '0;
            vvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            int_meta_q  <= int_meta_d;
            int_sync_q  <= int_sync_d;
            icw_q       <= icw_d;
            step_q      <= step_d;
            in_init_q   <= in_init_d;
            init_done_q <= init_done_d;
            a0_q        <= a0_d;
            dout_q      <= dout_d;
            vector_q    <= vector_d;
            vvalid_q    <= vvalid_d;
        end
    end

    assign bus.CS_n     = !(state_q == WR_SETUP || state_q == WR_STROBE || state_q == WR_HOLD);
    assign bus.WR_n     = (state_q != WR_STROBE);
    assign bus.INTA_n   = !(state_q == ACK1 || state_q == ACK2);
    assign bus.A0       = a0_q;
    assign bus.DATA_OUT = dout_q;

    assign cmd_ready    = (state_q == IDLE) && init_done_q && !start_init && !int_sync_q;
    assign vector       = vector_q;
    assign vector_valid = vvalid_q;
    assign init_done    = init_done_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_pic_host_sequencer.sv
// Bench for pic_host_sequencer: table-driven init vectors, directed corner sequences
// and randomized OCW/acknowledge traffic checked against a bus-level reference model.
module tb_pic_host_sequencer;
    localparam int unsigned P = 2;
    localparam int unsigned G = 1;
    localparam int unsigned WR_CYC  = 2 + P + G;
    localparam int unsigned ACK_CYC = 2 * P + 2 * G + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_init;
    logic [7:0] icw1, icw2, icw3, icw4;
    logic       eoi_en;
    logic       cmd_valid;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic [7:0] vector;
    logic       vector_valid;
    logic       init_done;
    logic       busy;

    pic_host_sequencer_if bus();

    pic_host_sequencer #(
        .PULSE_CYCLES(P),
        .GAP_CYCLES  (G)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_init  (start_init),
        .icw1        (icw1),
        .icw2        (icw2),
        .icw3        (icw3),
        .icw4        (icw4),
        .eoi_en      (eoi_en),
        .cmd_valid   (cmd_valid),
        .cmd_a0      (cmd_a0),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .bus         (bus),
        .vector      (vector),
        .vector_valid(vector_valid),
        .init_done   (init_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a0;
        logic [7:0]  data;
        int unsigned len;
    } wr_t;

    typedef struct {
        logic [7:0]  i1, i2, i3, i4;
        int unsigned nwr;
        int unsigned cyc;
    } init_vec_t;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Bus monitor state, sampled on the falling edge.
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    int unsigned fall_q[$];
    int unsigned rise_q[$];
    byte         ev_q[$];
    int unsigned mcyc = 0;
    int unsigned wr_len = 0;
    logic        wr_a0 = 1'b0;
    logic [7:0]  wr_dat = '0;
    logic        inta_prev = 1'b0;
    int unsigned vv_cnt = 0;
    int unsigned bad_cnt = 0;

    always @(negedge clk) begin
        mcyc++;
        if (reset) begin
            wr_len    = 0;
            inta_prev = 1'b0;
        end else begin
            if (!bus.WR_n) begin
                if (wr_len == 0) ev_q.push_back(8'h57);
                else if (bus.A0 !== wr_a0 || bus.DATA_OUT !== wr_dat) bad_cnt++;
                wr_len++;
                wr_a0  = bus.A0;
                wr_dat = bus.DATA_OUT;
                if (bus.CS_n) bad_cnt++;
            end else if (wr_len != 0) begin
                wr_q.push_back('{wr_a0, wr_dat, wr_len});
                wr_len = 0;
            end
            if (!bus.INTA_n) begin
                if (!inta_prev) begin
                    fall_q.push_back(mcyc);
                    ev_q.push_back(8'h41);
                end
                if (!bus.CS_n) bad_cnt++;
            end else if (inta_prev) begin
                rise_q.push_back(mcyc);
            end
            inta_prev = !bus.INTA_n;
            if (vector_valid) vv_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        wr_q.delete();
        exp_q.delete();
        fall_q.delete();
        rise_q.delete();
        ev_q.delete();
        vv_cnt = 0;
    endtask

    task automatic model_init(input logic [7:0] a, b, c, d);
        exp_q.delete();
        exp_q.push_back('{1'b0, a, P});
        exp_q.push_back('{1'b1, b, P});
        if (!a[1]) exp_q.push_back('{1'b1, c, P});
        if (a[0])  exp_q.push_back('{1'b1, d, P});
    endtask

    task automatic cmp_writes(input string nm);
        int unsigned n;
        chk({nm, ".wr_count"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < int'(n); i++) begin
            chk({nm, ".wr_a0"},   {31'd0, wr_q[i].a0}, {31'd0, exp_q[i].a0});
            chk({nm, ".wr_data"}, {24'd0, wr_q[i].data}, {24'd0, exp_q[i].data});
            chk({nm, ".wr_len"},  wr_q[i].len, exp_q[i].len);
        end
    endtask

    task automatic wait_idle(input string nm, input int unsigned budget);
        int unsigned n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk({nm, ".idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_init(input string nm, input logic [7:0] a, b, c, d, input int unsigned exp_cyc);
        int unsigned cyc = 0;
        clr();
        model_init(a, b, c, d);
        icw1 = a; icw2 = b; icw3 = c; icw4 = d;
        start_init = 1'b1;
        step();
        start_init = 1'b0;
        icw1 = 8'($urandom); icw2 = 8'($urandom); icw3 = 8'($urandom); icw4 = 8'($urandom);
        chk({nm, ".busy_at_start"}, {31'd0, busy}, 32'd1);
        chk({nm, ".done_cleared"}, {31'd0, init_done}, 32'd0);
        while (!init_done && cyc < 200) begin
            step();
            cyc++;
        end
        chk({nm, ".init_cycles"}, cyc, exp_cyc);
        chk({nm, ".busy_after"}, {31'd0, busy}, 32'd0);
        cmp_writes(nm);
    endtask

    init_vec_t   tbl[4];
    logic [7:0]  dseq[40];
    int unsigned lat, bcnt, j, n, rdy_seen, drop;
    logic        acc, ra0, reoi;
    logic [7:0]  rdat;

    initial begin
        tbl[0] = '{8'h13, 8'h20, 8'h00, 8'h01, 3, 15};
        tbl[1] = '{8'h11, 8'h40, 8'h04, 8'h1D, 4, 20};
        tbl[2] = '{8'h12, 8'h08, 8'hAA, 8'h00, 2, 10};
        tbl[3] = '{8'h10, 8'h30, 8'h02, 8'h00, 3, 15};

        reset = 1'b1; start_init = 1'b0; eoi_en = 1'b0;
        icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0;
        cmd_valid = 1'b0; cmd_a0 = 1'b0; cmd_data = '0;
        bus.INT = 1'b0; bus.DATA_IN = '0;
        repeat (3) step();
        chk("rst.CS_n",   {31'd0, bus.CS_n},   32'd1);
        chk("rst.WR_n",   {31'd0, bus.WR_n},   32'd1);
        chk("rst.INTA_n", {31'd0, bus.INTA_n}, 32'd1);
        chk("rst.A0",     {31'd0, bus.A0},     32'd0);
        chk("rst.DATA_OUT", {24'd0, bus.DATA_OUT}, 32'd0);
        chk("rst.vector", {24'd0, vector}, 32'd0);
        chk("rst.flags",  {28'd0, vector_valid, init_done, busy, cmd_ready}, 32'd0);
        reset = 1'b0;
        step();

        // INT and cmd before init are ignored.
        clr();
        bus.INT = 1'b1; cmd_valid = 1'b1; rdy_seen = 0;
        repeat (10) begin
            step();
            if (cmd_ready) rdy_seen++;
        end
        chk("preinit.inta_pulses", fall_q.size(), 0);
        chk("preinit.cmd_ready", rdy_seen, 0);
        chk("preinit.busy", {31'd0, busy}, 32'd0);
        chk("preinit.writes", wr_q.size(), 0);
        bus.INT = 1'b0; cmd_valid = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 4; i++) begin
            chk("tbl.nwr_model", exp_q.size(), exp_q.size());
            run_init($sformatf("init%0d", i), tbl[i].i1, tbl[i].i2, tbl[i].i3, tbl[i].i4, tbl[i].cyc);
            chk($sformatf("init%0d.nwr", i), wr_q.size(), tbl[i].nwr);
        end

        // Acknowledge with EOI, INT dropped once the first INTA pulse starts.
        clr();
        bus.DATA_IN = 8'h23; eoi_en = 1'b1; bus.INT = 1'b1; lat = 0;
        while (bus.INTA_n && lat < 20) begin
            step();
            lat++;
        end
        chk("ack.latency", lat, 3);
        bus.INT = 1'b0;
        wait_idle("ack", 50);
        chk("ack.pulses", fall_q.size(), 2);
        if (fall_q.size() == 2 && rise_q.size() == 2) begin
            chk("ack.pulse1_len", rise_q[0] - fall_q[0], P);
            chk("ack.pulse2_len", rise_q[1] - fall_q[1], P);
            chk("ack.pulse_gap",  fall_q[1] - rise_q[0], G);
        end
        chk("ack.vector", {24'd0, vector}, 32'h23);
        chk("ack.vv_pulses", vv_cnt, 1);
        exp_q.delete();
        exp_q.push_back('{1'b0, 8'h20, P});
        cmp_writes("ack.eoi");

        // INT wins over a simultaneous cmd; cmd follows afterwards.
        clr();
        eoi_en = 1'b0; bus.DATA_IN = 8'h5A; bus.INT = 1'b1;
        step(); step();
        cmd_valid = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'hFE;
        chk("prio.ready_blocked", {31'd0, cmd_ready}, 32'd0);
        acc = 1'b0; n = 0;
        while (!acc && n < 60) begin
            if (cmd_ready) begin
                step();
                acc = 1'b1;
            end else begin
                step();
                if (!bus.INTA_n) bus.INT = 1'b0;
            end
            n++;
        end
        cmd_valid = 1'b0;
        chk("prio.accepted", {31'd0, acc}, 32'd1);
        chk("prio.setup_cs", {30'd0, bus.CS_n, bus.WR_n}, 32'd1);
        wait_idle("prio", 50);
        chk("prio.first_event", {24'd0, ev_q.size() > 0 ? ev_q[0] : 8'h00}, 32'h41);
        chk("prio.vector", {24'd0, vector}, 32'h5A);
        exp_q.delete();
        exp_q.push_back('{1'b1, 8'hFE, P});
        cmp_writes("prio.cmd");

        // Reset in the middle of an acknowledge.
        clr();
        bus.DATA_IN = 8'h77; bus.INT = 1'b1; n = 0;
        while (bus.INTA_n && n < 20) begin step(); n++; end
        n = 0;
        while (!bus.INTA_n && n < 20) begin step(); n++; end
        chk("rstgap.in_gap", {30'd0, busy, bus.INTA_n}, 32'd3);
        reset = 1'b1;
        step();
        chk("rstgap.INTA_n", {31'd0, bus.INTA_n}, 32'd1);
        chk("rstgap.busy", {31'd0, busy}, 32'd0);
        chk("rstgap.init_done", {31'd0, init_done}, 32'd0);
        chk("rstgap.vector", {24'd0, vector}, 32'd0);
        reset = 1'b0; bus.INT = 1'b0;
        repeat (8) step();
        chk("rstgap.no_vv", vv_cnt, 0);
        chk("rstgap.pulses", fall_q.size(), 1);

        // start_init during an OCW write is dropped.
        run_init("reinit", 8'h13, 8'h20, 8'h00, 8'h01, 15);
        clr();
        cmd_valid = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h0B;
        chk("stw.ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        icw1 = 8'h12; start_init = 1'b1;
        step();
        start_init = 1'b0;
        drop = 0; n = 0;
        while (busy && n < 40) begin
            if (!init_done) drop++;
            step();
            n++;
        end
        repeat (4) begin
            if (!init_done || busy) drop++;
            step();
        end
        chk("stw.init_kept", drop, 0);
        exp_q.delete();
        exp_q.push_back('{1'b0, 8'h0B, P});
        cmp_writes("stw");

        // Randomized OCW writes and acknowledges against the bus-level model.
        for (int it = 0; it < 40; it++) begin
            clr();
            if ($urandom_range(0, 1) == 0) begin
                ra0 = 1'($urandom); rdat = 8'($urandom);
                cmd_valid = 1'b1; cmd_a0 = ra0; cmd_data = rdat;
                chk("rnd.cmd_ready", {31'd0, cmd_ready}, 32'd1);
                step();
                cmd_valid = 1'b0; cmd_a0 = 1'($urandom); cmd_data = 8'($urandom);
                bcnt = 1; j = 0;
                while (busy && j < 40) begin
                    step();
                    j++;
                    if (busy) bcnt++;
                end
                chk("rnd.cmd_cycles", bcnt, WR_CYC);
                chk("rnd.hold", {23'd0, bus.A0, bus.DATA_OUT}, {23'd0, ra0, rdat});
                exp_q.push_back('{ra0, rdat, P});
                cmp_writes("rnd.cmd");
            end else begin
                reoi = 1'($urandom); eoi_en = reoi;
                for (int k = 0; k < 40; k++) dseq[k] = 8'($urandom);
                bus.DATA_IN = 8'($urandom); bus.INT = 1'b1; lat = 0;
                while (bus.INTA_n && lat < 20) begin
                    step();
                    lat++;
                end
                chk("rnd.ack_latency", lat, 3);
                bus.INT = 1'b0;
                bcnt = 1; j = 0;
                while (busy && j < 39) begin
                    bus.DATA_IN = dseq[j];
                    step();
                    j++;
                    if (busy) bcnt++;
                end
                chk("rnd.ack_cycles", bcnt, ACK_CYC + (reoi ? WR_CYC : 0));
                chk("rnd.vector", {24'd0, vector}, {24'd0, dseq[2 * P + G - 1]});
                chk("rnd.vv_pulses", vv_cnt, 1);
                chk("rnd.pulses", fall_q.size(), 2);
                if (reoi) exp_q.push_back('{1'b0, 8'h20, P});
                cmp_writes("rnd.ack");
            end
            repeat ($urandom_range(0, 3)) step();
        end

        chk("monitor.protocol", bad_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
